fp_norm_pipe: RTL

Parametrised, pipelined post-add normaliser for the floating-point adder datapath: takes the raw sum (sign, exponent, carry-extended mantissa) and produces a normalised or denormal result with overflow/zero/denormal flags. It generalises the adder's combinational normalise step in three ways:
- Widths are parametrised.
- Carry-out right-normalisation (with sticky) and exponent-underflow clamping are handled.
- It runs as a 2-stage valid/ready pipeline between the adder core and the rounding stage.

---
 rtl/fp_norm_pkg.sv | 34 +++
 rtl/norm_lzc.sv | 31 +++
 rtl/fp_norm_pipe.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fp_norm_pkg.sv
// ============================================================================
// Module      : fp_norm_pkg
// Description : Shared constants, types and helpers for the floating-point
//               post-add normaliser pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_norm_pkg;

    // Default datapath widths (mantissa includes the hidden bit).
    localparam int MANT_W_DEF = 28;
    localparam int EXP_W_DEF  = 8;

    // All-ones biased exponent for a given exponent width (Inf/NaN code).
    function automatic int exp_max(input int w);
        return (1 << w) - 1;
    endfunction

    // Stage-1 register layout for the default configuration. The top level
    // declares the same layout sized by its own parameters.
    typedef struct packed {
        logic                             sign;
        logic [EXP_W_DEF-1:0]             exp;
        logic [MANT_W_DEF:0]              mant;
        logic                             c;
        logic                             z;
        logic                             sp;
        logic [$clog2(MANT_W_DEF+1)-1:0]  lzc;
    } s1_reg_t;

endpackage

`default_nettype wire

// File: rtl/norm_lzc.sv
// ============================================================================
// Module      : norm_lzc
// Description : Combinational leading-zero counter. Returns W for an all-zero
//               input.
// Ports       : vec_i [W-1:0]  vector to scan (MSB first)
//               cnt_o [CW-1:0] number of leading zeros, 0..W
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module norm_lzc #(
    parameter  int W  = 28,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec_i,
    output logic [CW-1:0] cnt_o
);

    // Scan from LSB upward; the last (highest) set bit found wins.
    always_comb begin
        cnt_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (vec_i[i]) begin
                cnt_o = CW'(W - 1 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_norm_pipe.sv
// ============================================================================
// Module      : fp_norm_pipe
// Description : Two-stage valid/ready post-add normaliser. Stage 1 registers
//               the raw sum with carry/zero/special flags and leading-zero
//               count; stage 2 shifts the mantissa and adjusts the exponent,
//               producing overflow, zero and denormal flags.
// Ports       : clk, rst_n                 clock, async active-low reset
//               in_valid_i / in_ready_o    input handshake
//               in_sign_i, in_exp_i, in_mant_i (bit MANT_W = carry-out)
//               out_valid_o / out_ready_i  output handshake
//               out_sign_o, out_exp_o, out_mant_o,
//               out_zero_o, out_ovf_o, out_denorm_o
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_norm_pipe
    import fp_norm_pkg::*;
#(
    parameter  int MANT_W = MANT_W_DEF,
    parameter  int EXP_W  = EXP_W_DEF,
    localparam int SH_W   = $clog2(MANT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_sign_i,
    input  logic [EXP_W-1:0]  in_exp_i,
    input  logic [MANT_W:0]   in_mant_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_sign_o,
    output logic [EXP_W-1:0]  out_exp_o,
    output logic [MANT_W-1:0] out_mant_o,
    output logic              out_zero_o,
    output logic              out_ovf_o,
    output logic              out_denorm_o
);

    localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(exp_max(EXP_W));

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W:0]   mant;
        logic              c;
        logic              z;
        logic              sp;
        logic [SH_W-1:0]   lzc;
    } s1_t;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic s2_valid_q;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv      = !s2_valid_q || out_ready_i;
    assign s1_adv      = !s1_valid_q || s2_adv;
    assign in_ready_o  = s1_adv;
    assign out_valid_o = s2_valid_q;

    // ------------------------------------------------------------------
    // Stage 1: capture raw sum and pre-computed flags
    // ------------------------------------------------------------------
    logic [SH_W-1:0] in_lzc;
    s1_t             s1_d;
    s1_t             s1_q;

    norm_lzc #(.W(MANT_W)) u_lzc (
        .vec_i (in_mant_i[MANT_W-1:0]),
        .cnt_o (in_lzc)
    );

    always_comb begin
        s1_d.sign = in_sign_i;
        s1_d.exp  = in_exp_i;
        s1_d.mant = in_mant_i;
        s1_d.c    = in_mant_i[MANT_W];
        s1_d.z    = (in_mant_i == '0);
        s1_d.sp   = (in_exp_i == EXP_ONES);
        s1_d.lzc  = in_lzc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid_i;
        end
    end

    // Data register is not reset; it is qualified by s1_valid_q.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid_i) begin
            s1_q <= s1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: normalise
    // ------------------------------------------------------------------
    logic [EXP_W:0]    exp_x;
    logic [EXP_W:0]    exp_inc;
    logic [EXP_W:0]    lzc_x;
    logic              norm_ok;
    logic              exp_ovf;
    logic [SH_W-1:0]   shamt;
    logic [MANT_W-1:0] shifted;

    // One bit of headroom so the increment and compares never wrap.
    assign exp_x   = {1'b0, s1_q.exp};
    assign exp_inc = exp_x + (EXP_W + 1)'(1);
    assign lzc_x   = (EXP_W + 1)'(s1_q.lzc);
    assign norm_ok = (lzc_x < exp_x);
    assign exp_ovf = (exp_inc == {1'b0, EXP_ONES});

    // Underflow shifts only far enough to reach the denormal exponent;
    // that amount is below lzc, so it always fits in SH_W bits.
    assign shamt = norm_ok            ? s1_q.lzc :
                   (s1_q.exp == '0)   ? '0       :
                   SH_W'(s1_q.exp - EXP_W'(1));

    // Log-depth barrel shifter, zero fill.
    always_comb begin
        shifted = s1_q.mant[MANT_W-1:0];
        for (int k = 0; k < SH_W; k++) begin
            if (shamt[k]) begin
                shifted = shifted << (1 << k);
            end
        end
    end

    logic              sign_d;
    logic [EXP_W-1:0]  exp_d;
    logic [MANT_W-1:0] mant_d;
    logic              zero_d;
    logic              ovf_d;
    logic              denorm_d;

    always_comb begin
        sign_d   = s1_q.sign;
        exp_d    = '0;
        mant_d   = '0;
        zero_d   = 1'b0;
        ovf_d    = 1'b0;
        denorm_d = 1'b0;
        if (s1_q.sp) begin
            exp_d  = s1_q.exp;
            mant_d = s1_q.mant[MANT_W-1:0];
        end else if (s1_q.z) begin
            zero_d = 1'b1;
        end else if (s1_q.c) begin
            if (exp_ovf) begin
                ovf_d = 1'b1;
                exp_d = EXP_ONES;
            end else begin
                exp_d  = exp_inc[EXP_W-1:0];
                mant_d = {s1_q.mant[MANT_W:2], s1_q.mant[1] | s1_q.mant[0]};
            end
        end else if (norm_ok) begin
            exp_d  = s1_q.exp - EXP_W'(s1_q.lzc);
            mant_d = shifted;
        end else begin
            mant_d   = shifted;
            denorm_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            out_sign_o   <= 1'b0;
            out_exp_o    <= '0;
            out_mant_o   <= '0;
            out_zero_o   <= 1'b0;
            out_ovf_o    <= 1'b0;
            out_denorm_o <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_sign_o   <= sign_d;
                out_exp_o    <= exp_d;
                out_mant_o   <= mant_d;
                out_zero_o   <= zero_d;
                out_ovf_o    <= ovf_d;
                out_denorm_o <= denorm_d;
            end
        end
    end

endmodule

`default_nettype wire
